// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file write-back arbiter.
package wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  // One queued register-file write.
  typedef struct packed {
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Completion source identifier, also used as the round-robin pointer.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;

  // One-hot register mask; register 0 never shows up as pending.
  function automatic logic [NREGS-1:0] rw_onehot(input logic [ADDR_W-1:0] rw);
    logic [NREGS-1:0] m;
    m    = {{(NREGS-1){1'b0}}, 1'b1} << rw;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of write-back entries with a per-slot valid/rw view.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  wb_entry_t                       push_entry,
  input  logic                            pop,
  output logic                            full,
  output logic                            empty,
  output wb_entry_t                       head,
  output logic [DEPTH-1:0]                entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]    entry_rw
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_INC   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] EMPTY_CNT = (PTR_W+1)'(0);

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W:0]   wr_ptr_r;
  logic [PTR_W:0]   rd_ptr_r;
  logic [PTR_W:0]   count_s;
  logic             do_push_s;
  logic             do_pop_s;

  // Occupancy from wrap-extended pointers gives exact full/empty.
  always_comb begin
    count_s   = wr_ptr_r - rd_ptr_r;
    full      = (count_s == FULL_CNT);
    empty     = (count_s == EMPTY_CNT);
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    head      = mem_r[rd_ptr_r[PTR_W-1:0]];
  end

  // Slot i is live when its distance from the read pointer is below occupancy.
  always_comb begin
    entry_valid = '0;
    entry_rw    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = {1'b0, PTR_W'(PTR_W'(i) - rd_ptr_r[PTR_W-1:0])} < count_s;
      entry_rw[i]    = mem_r[i].rw;
    end
  end

  // Entry storage; contents are only meaningful under entry_valid.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= push_entry;
    end
  end

  // Read/write pointers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= EMPTY_CNT;
      rd_ptr_r <= EMPTY_CNT;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_INC;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_INC;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register-file write port.
module regfile_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rw,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rw,
  input  logic [DATA_W-1:0] mem_data,
  output logic              reg_write,
  output logic [ADDR_W-1:0] rw,
  output logic [DATA_W-1:0] data,
  output logic [31:0]       pending_mask
);

  import wb_pkg::*;

  wb_entry_t                  alu_head_s, mem_head_s, grant_entry_s;
  wb_entry_t                  alu_entry_s, mem_entry_s;
  logic                       alu_full_s, alu_empty_s, mem_full_s, mem_empty_s;
  logic [DEPTH-1:0]           alu_ev_s, mem_ev_s;
  logic [DEPTH-1:0][ADDR_W-1:0] alu_erw_s, mem_erw_s;
  logic                       alu_hit_s, mem_hit_s, alu_nz_s, mem_nz_s, tie_s;
  logic                       alu_push_s, mem_push_s, alu_pop_s, mem_pop_s;
  logic                       grant_valid_s;
  wb_src_t                    grant_src_s;
  wb_src_t                    last_r;

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk(CLK), .rst(rst), .push(alu_push_s), .push_entry(alu_entry_s),
    .pop(alu_pop_s), .full(alu_full_s), .empty(alu_empty_s), .head(alu_head_s),
    .entry_valid(alu_ev_s), .entry_rw(alu_erw_s)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk(CLK), .rst(rst), .push(mem_push_s), .push_entry(mem_entry_s),
    .pop(mem_pop_s), .full(mem_full_s), .empty(mem_empty_s), .head(mem_head_s),
    .entry_valid(mem_ev_s), .entry_rw(mem_erw_s)
  );

  // Ready: keep every write to one register in a single FIFO; a same-cycle
  // tie goes to the load, which is treated as older.
  always_comb begin
    alu_hit_s = 1'b0;
    mem_hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      alu_hit_s = alu_hit_s | (mem_ev_s[i] && (mem_erw_s[i] == alu_rw));
      mem_hit_s = mem_hit_s | (alu_ev_s[i] && (alu_erw_s[i] == mem_rw));
    end
    alu_nz_s    = (alu_rw != ADDR_W'(0));
    mem_nz_s    = (mem_rw != ADDR_W'(0));
    tie_s       = alu_valid && mem_valid && alu_nz_s && (alu_rw == mem_rw);
    alu_ready   = !alu_full_s && !(alu_nz_s && alu_hit_s) && !tie_s;
    mem_ready   = !mem_full_s && !(mem_nz_s && mem_hit_s);
    alu_push_s  = alu_valid && alu_ready && alu_nz_s;
    mem_push_s  = mem_valid && mem_ready && mem_nz_s;
    alu_entry_s = '{rw: alu_rw, data: alu_data};
    mem_entry_s = '{rw: mem_rw, data: mem_data};
  end

  // Round-robin grant between the two FIFO heads.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_src_s   = SRC_ALU;
    case ({!alu_empty_s, !mem_empty_s})
      2'b11: begin
        grant_valid_s = 1'b1;
        grant_src_s   = (last_r == SRC_ALU) ? SRC_MEM : SRC_ALU;
      end
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_src_s   = SRC_ALU;
      end
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_src_s   = SRC_MEM;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_src_s   = SRC_ALU;
      end
    endcase
    alu_pop_s     = grant_valid_s && (grant_src_s == SRC_ALU);
    mem_pop_s     = grant_valid_s && (grant_src_s == SRC_MEM);
    grant_entry_s = (grant_src_s == SRC_MEM) ? mem_head_s : alu_head_s;
  end

  // Registered write port and round-robin pointer; reset drops reg_write at once.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      reg_write <= 1'b0;
      rw        <= ADDR_W'(0);
      data      <= DATA_W'(0);
      last_r    <= SRC_MEM;
    end else begin
      reg_write <= grant_valid_s;
      if (grant_valid_s) begin
        rw     <= grant_entry_s.rw;
        data   <= grant_entry_s.data;
        last_r <= grant_src_s;
      end
    end
  end

  // Pending mask: every live FIFO entry plus the write being presented.
  always_comb begin
    pending_mask = 32'h0000_0000;
    for (int i = 0; i < DEPTH; i++) begin
      pending_mask = pending_mask | (alu_ev_s[i] ? rw_onehot(alu_erw_s[i]) : 32'h0000_0000);
      pending_mask = pending_mask | (mem_ev_s[i] ? rw_onehot(mem_erw_s[i]) : 32'h0000_0000);
    end
    pending_mask = pending_mask | (reg_write ? rw_onehot(rw) : 32'h0000_0000);
  end

endmodule
